// File: rtl/req_arbiter.sv
// Round-robin arbiter feeding the 8-to-3 encoder: one registered one-hot grant, held until ack or timeout.
// Optional macro ARB_STICKY_PENDING_EN keeps single-cycle request pulses in a pending register.
module req_arbiter #(
    parameter int N        = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic         timeout
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(HOLD_MAX + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_n;
    logic [PW-1:0]  ptr, ptr_n;
    logic [PW-1:0]  cur, cur_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [N-1:0]   grant_n;
    logic           grant_valid_n;
    logic           timeout_n;
    logic [N-1:0]   elig;
    logic [PW-1:0]  sel;
    logic           found;

`ifdef ARB_STICKY_PENDING_EN
    logic [N-1:0] pending, pending_n;

    assign elig = pending | req;

    // The bit granted on the issue edge is cleared even if it is re-requested on that edge.
    always_comb begin
        pending_n = pending | req;
        if (state == IDLE && found) begin
            pending_n[sel] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_n;
        end
    end
`else
    assign elig = req;
`endif

    // First eligible bit scanning ptr, ptr+1, ... with wrap.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && elig[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr) + i) % N);
            end
        end
    end

    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        cur_n         = cur;
        cnt_n         = cnt;
        grant_n       = grant;
        grant_valid_n = grant_valid;
        timeout_n     = 1'b0;
        case (state)
            IDLE: begin
                grant_n       = '0;
                grant_valid_n = 1'b0;
                if (found) begin
                    grant_n       = {{(N-1){1'b0}}, 1'b1} << sel;
                    grant_valid_n = 1'b1;
                    cur_n         = sel;
                    cnt_n         = '0;
                    state_n       = GRANT;
                end
            end
            GRANT: begin
                // ack takes priority over a timeout landing on the same edge.
                if (ack || cnt == CW'(HOLD_MAX - 1)) begin
                    grant_n       = '0;
                    grant_valid_n = 1'b0;
                    timeout_n     = !ack;
                    ptr_n         = (cur == PW'(N - 1)) ? '0 : cur + 1'b1;
                    state_n       = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n       = IDLE;
                grant_n       = '0;
                grant_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cur         <= '0;
            cnt         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            cur         <= cur_n;
            cnt         <= cnt_n;
            grant       <= grant_n;
            grant_valid <= grant_valid_n;
            timeout     <= timeout_n;
        end
    end
endmodule
